// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter, one frame at a time.
// Ports: clk/rst, in_valid/in_data/in_ready, flush, transmit/tx_byte, is_transmitting, fifo_count/empty/full/busy/tx_error.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  input  logic              is_transmitting,
  output logic [ADDR_W:0]   fifo_count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              tx_error
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  state_e            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              transmit_q, transmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_error_q, tx_error_d;
  logic              wr_en;
  logic              pop;

  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready   = !full && !rst && !flush;
  assign wr_en      = in_valid && in_ready;
  // Launch only from IDLE with the UART quiet; flush wins over a launch.
  assign pop        = (state_q == IDLE) && !empty
                      && !is_transmitting && !flush;

  assign fifo_count = count_q;
  assign transmit   = transmit_q;
  assign tx_byte    = tx_byte_q;
  assign tx_error   = tx_error_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    tmo_d      = tmo_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_error_d = tx_error_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_byte_d  = mem_q[rd_ptr_q];
          transmit_d = 1'b1;
          tmo_d      = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + 1'b1;
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged: drop the byte, flag it.
          tx_error_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      tmo_q      <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      tx_error_q <= tx_error_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a small UART model.
// The model holds is_transmitting for FRAME cycles per strobe, or can be forced busy / dead.
module tb_uart_tx_fifo;

  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_tx;
  logic [4:0] fifo_count;
  logic       empty;
  logic       full;
  logic       busy;
  logic       tx_error;

  logic       hold_busy;
  logic       dead;
  int         fc;
  logic       it_prev;
  logic       tx_prev;
  int         viol;
  int         wviol;
  logic [7:0] sent [$];

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_fifo #(
    .DEPTH(16), .ADDR_W(4), .BUSY_TIMEOUT(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .transmit(transmit),
    .tx_byte(tx_byte),
    .is_transmitting(is_tx),
    .fifo_count(fifo_count),
    .empty(empty),
    .full(full),
    .busy(busy),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  assign is_tx = hold_busy || (fc != 0);

  always @(posedge clk) begin
    if (rst) fc <= 0;
    else if (transmit && !dead) fc <= FRAME;
    else if (fc != 0) fc <= fc - 1;
  end

  // Record each strobe; flag strobes launched while UART was busy or wider than 1 cycle.
  always @(posedge clk) begin
    if (transmit) begin
      sent.push_back(tx_byte);
      if (it_prev) viol = viol + 1;
      if (tx_prev) wviol = wviol + 1;
    end
    it_prev <= is_tx;
    tx_prev <= transmit;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    while ((busy || !empty) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(busy || !empty), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    hold_busy = 1'b0; dead = 1'b0; fc = 0;
    it_prev = 1'b0; tx_prev = 1'b0; viol = 0; wviol = 0;
    tick(2);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_transmit", 32'(transmit), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1 chk("rst_ready_after", 32'(in_ready), 1);

    // single byte, launch latency
    sent.delete();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t1_count_w", 32'(fifo_count), 1);
    chk("t1_no_tx_e0", 32'(transmit), 0);
    tick();
    chk("t1_tx_e1", 32'(transmit), 1);
    chk("t1_byte", 32'(tx_byte), 32'hA5);
    chk("t1_count_pop", 32'(fifo_count), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_tx_width", 32'(transmit), 0);
    chk("t1_uart_busy", 32'(is_tx), 1);
    chk("t1_busy2", 32'(busy), 1);
    wait_idle(40, "t1");
    chk("t1_uart_done", 32'(is_tx), 0);
    chk("t1_byte_held", 32'(tx_byte), 32'hA5);
    chk("t1_n", 32'(sent.size()), 1);

    // five back-to-back bytes
    sent.delete();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_idle(200, "t2");
    chk("t2_n", 32'(sent.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("t2_byte", 32'(sent[i]), 32'(i + 1));
    chk("t2_overlap", 32'(viol), 0);
    chk("t2_width", 32'(wviol), 0);

    // fill past full while UART held busy, then drain through wrap
    sent.delete();
    hold_busy = 1'b1;
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      #1;
      if (in_ready) acc++;
      if (i >= 16) chk("t3_ready_full", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 16);
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(fifo_count), 16);
    chk("t3_no_tx", 32'(sent.size()), 0);
    hold_busy = 1'b0;
    wait_idle(400, "t3");
    chk("t3_n", 32'(sent.size()), 16);
    for (int i = 0; i < 16; i++)
      chk("t3_byte", 32'(sent[i]), 32'(8'h10 + i));
    chk("t3_overlap", 32'(viol), 0);

    // write coincides with launch at count 3
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i);
      tick();
    end
    hold_busy = 1'b0;
    in_data = 8'h34;
    tick();
    in_valid = 1'b0;
    chk("t4_count_same", 32'(fifo_count), 3);
    chk("t4_tx", 32'(transmit), 1);
    chk("t4_byte", 32'(tx_byte), 32'h31);
    wait_idle(200, "t4a");
    chk("t4_n", 32'(sent.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_order", 32'(sent[i]), 32'(8'h31 + i));

    // flush with a write pending and a frame in flight
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h41 + i);
      tick();
    end
    in_valid = 1'b0;
    hold_busy = 1'b0;
    tick();
    chk("t4f_tx", 32'(transmit), 1);
    chk("t4f_count4", 32'(fifo_count), 4);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1 chk("t4f_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4f_count0", 32'(fifo_count), 0);
    chk("t4f_empty", 32'(empty), 1);
    chk("t4f_busy", 32'(busy), 1);
    wait_idle(100, "t4f");
    tick(5);
    chk("t4f_n", 32'(sent.size()), 1);
    chk("t4f_byte", 32'(sent[0]), 32'h41);
    chk("t4f_no_err", 32'(tx_error), 0);

    // UART never answers: timeout
    dead = 1'b1;
    in_valid = 1'b1; in_data = 8'h51;
    tick();
    in_data = 8'h52;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!transmit && n < 20) begin
      tick();
      n++;
    end
    chk("t5_launch", 32'(transmit), 1);
    chk("t5_byte51", 32'(tx_byte), 32'h51);
    tick(6);
    chk("t5_err_early", 32'(tx_error), 0);
    chk("t5_busy_wb", 32'(busy), 1);
    tick();
    chk("t5_err", 32'(tx_error), 1);
    chk("t5_idle", 32'(busy), 0);
    tick();
    chk("t5_next_tx", 32'(transmit), 1);
    chk("t5_byte52", 32'(tx_byte), 32'h52);
    wait_idle(50, "t5a");
    chk("t5_sticky", 32'(tx_error), 1);
    dead = 1'b0;
    in_valid = 1'b1; in_data = 8'h53;
    tick();
    in_valid = 1'b0;
    wait_idle(50, "t5b");
    chk("t5_sticky2", 32'(tx_error), 1);
    chk("t5_byte53", 32'(tx_byte), 32'h53);

    // reset in WAIT_DONE with 5 stored
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i);
      tick();
    end
    in_valid = 1'b0;
    hold_busy = 1'b0;
    tick();
    chk("t6_launch", 32'(transmit), 1);
    tick(3);
    chk("t6_count5", 32'(fifo_count), 5);
    chk("t6_uart", 32'(is_tx), 1);
    chk("t6_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_tx", 32'(transmit), 0);
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_tx_byte", 32'(tx_byte), 0);
    chk("t6_err", 32'(tx_error), 0);
    rst = 1'b0;
    #1 chk("t6_ready", 32'(in_ready), 1);
    tick(3);
    chk("t6_stay_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-wide transmit buffer that sits directly upstream of the team's UART transmitter. It accepts bytes from the core over a valid/ready handshake and stores them in a DEPTH-entry circular FIFO. It drains the FIFO one byte at a time: it pulses the UART's transmit strobe, then tracks is_transmitting until each frame, including the UART's restart delay, has completed. A stuck-UART timeout raises a sticky error flag.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH).
BUSY_TIMEOUT, 7, cycles to wait for is_transmitting to rise after a launch before declaring an error; minimum 2.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  core offers a byte.
in_data  in  8  byte offered.
in_ready  out  1  FIFO can accept; equals !full && !rst && !flush (combinational).
flush  in  1  synchronous FIFO clear; the byte already launched is not aborted.
transmit  out  1  one-cycle strobe to the UART, registered.
tx_byte  out  8  byte for the UART, registered; held stable until the next launch.
is_transmitting  in  1  UART busy indication.
fifo_count  out  ADDR_W+1  stored entries, 0..DEPTH.
empty  out  1  fifo_count==0.
full  out  1  fifo_count==DEPTH.
busy  out  1  FSM not in IDLE.
tx_error  out  1  sticky; set on timeout, cleared only by rst.

Behaviour:
- Reset (clk edge with rst=1): wr_ptr=rd_ptr=0, fifo_count=0, empty=1, full=0, transmit=0, tx_byte=8'h00, tx_error=0, busy=0, state=IDLE, timeout counter=0. The storage array is not cleared. Reset mid-frame abandons the frame; the UART shares rst.
- Write: accepted on an edge where in_valid && in_ready. mem[wr_ptr]<=in_data, wr_ptr increments mod DEPTH.
- Full: in_ready=0 when full, even if a pop occurs in the same cycle; there is no full bypass.
- fifo_count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if !empty && !is_transmitting && !flush, then at the edge: tx_byte<=mem[rd_ptr], transmit<=1, rd_ptr increments mod DEPTH, pop, timeout counter<=0, go to WAIT_BUSY. Otherwise stay in IDLE.
- WAIT_BUSY: transmit<=0 at the first edge, so transmit is high for exactly one cycle. The counter increments each cycle.
  - is_transmitting=1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: tx_error<=1, go to IDLE; the byte is lost.
- WAIT_DONE: stay while is_transmitting=1. Go to IDLE on the first cycle it reads 0.
- Launch latency: write accepted at edge E0 into an empty FIFO with the FSM in IDLE and the UART idle gives transmit=1 between E1 and E2. The UART asserts is_transmitting from E2.
- Back-to-back: the next launch occurs no earlier than the IDLE cycle following is_transmitting falling. The UART's restart delay is respected because it holds is_transmitting high.
- flush: at the edge, wr_ptr<=rd_ptr and fifo_count<=0.
  - flush has priority over a simultaneous write (in_ready=0) and over a launch in IDLE.
  - FSM states WAIT_BUSY and WAIT_DONE proceed unaffected.
- Pointer wrap: the pointers are ADDR_W bits and wrap naturally. full/empty come from fifo_count only.
- transmit is never asserted while is_transmitting=1 is sampled in IDLE.

Test Plan:
- Reset, then write 8'hA5 once, with a UART model idle: transmit=1 exactly one cycle, 2 edges after the write edge; tx_byte=8'hA5; fifo_count back to 0; busy until is_transmitting falls.
- Write 8'h01..8'h05 back-to-back: exactly 5 transmit pulses, tx_byte 01,02,03,04,05 in order; each pulse occurs only after is_transmitting has dropped from the previous frame.
- Hold the UART busy and write DEPTH+2 bytes (16+2): in_ready=0 once fifo_count=16, full=1, the extra bytes are not stored; after release all 16 are sent in order, exercising wrap at rd_ptr=15->0.
- Simultaneous in_valid and launch at fifo_count=3: fifo_count stays 3 and the data order is preserved; flush asserted with in_valid=1 and fifo_count=4: fifo_count=0, the write is dropped, and an in-flight frame still completes.
- UART model never asserts is_transmitting after a strobe: tx_error=1 after BUSY_TIMEOUT (7) cycles in WAIT_BUSY; the FSM returns to IDLE and the next byte launches; tx_error stays 1 until rst.
- rst asserted during WAIT_DONE with fifo_count=5: the next cycle shows fifo_count=0, empty=1, transmit=0, busy=0, tx_byte=8'h00, tx_error=0.
